mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single data-side RAM port (read1/write port) between the CPU data path and
//  NUM_EXT external bus masters (DMA, debug loader). CPU has fixed priority; external masters
//  are round-robin among themselves and get a forced slot after STARVE_LIMIT denied cycles.
//  Sits between pipelined_cpu's data port and the RAM; cpu_hold gates the CPU clock enable.
// PARAMETERS
//  NUM_EXT       2   number of external masters (1..4)
//  STARVE_LIMIT  8   consecutive cycles an ext request may be denied before forced grant (>=1)
// PORTS
//  clk         in   1          system clock
//  rst_n       in   1          asynchronous active-low reset
//  cpu_req     in   1          CPU data access this cycle (load or store in MEM slot)
//  cpu_addr    in   18         CPU physical word address (post-TLB)
//  cpu_we      in   4          CPU byte write enables (0 = read)
//  cpu_wdata   in   32         CPU store data
//  cpu_rdata   out  32         read data, valid cycle after CPU grant
//  cpu_hold    out  1          CPU request denied this cycle; top level forces clk_en low
//  ext_req     in   NUM_EXT    per-master request, held until ext_gnt
//  ext_addr    in   18*NUM_EXT per-master address, master i at [18*i +: 18]
//  ext_we      in   4*NUM_EXT  per-master byte enables
//  ext_wdata   in   32*NUM_EXT per-master store data
//  ext_gnt     out  NUM_EXT    one-hot, combinational: access issued this cycle
//  ext_rvalid  out  NUM_EXT    one-hot pulse: ext_rdata belongs to master i
//  ext_rdata   out  32         shared read-return bus
//  ram_addr    out  18         to RAM
//  ram_we      out  4          to RAM; 0 when no owner
//  ram_wdata   out  32         to RAM
//  ram_rdata   in   32         RAM read data, 1-cycle synchronous latency
// BEHAVIOUR
//  - Reset: rr_ptr=0, starve_cnt=0, ret_owner=NONE; all outputs 0 (cpu_hold=0, gnt/rvalid=0).
//  - Owner chosen combinationally each cycle, at most one:
//    force = (starve_cnt == STARVE_LIMIT) && |ext_req
//    cpu_req && !force -> CPU; else any ext_req -> first requester at/after rr_ptr (wrap); else NONE.
//  - RAM mux: ram_addr/we/wdata from owner; NONE -> ram_we=0, ram_addr=0, ram_wdata=0.
//  - cpu_hold = cpu_req && owner!=CPU. CPU must hold addr/we/wdata stable while held.
//  - ext_gnt[i]=1 iff owner==EXT i. Master drops or changes request the cycle after gnt.
//  - starve_cnt: +1 when |ext_req && owner==CPU (saturates at STARVE_LIMIT);
//    cleared when any ext master granted or ext_req==0.
//  - rr_ptr: after granting master i, rr_ptr <= (i+1) mod NUM_EXT; unchanged otherwise.
//  - Read return: ret_owner register records owner of a granted read (we==0) cycle N;
//    cycle N+1: CPU -> cpu_rdata=ram_rdata; EXT i -> ext_rdata=ram_rdata, ext_rvalid[i]=1.
//    cpu_rdata/ext_rdata hold last returned value otherwise (registered capture not required;
//    outputs are ram_rdata gated). Writes produce no rvalid.
//  - Back-to-back grants to different owners allowed every cycle; return path pipelined.
//  - No assertion of ext_req[i] changes state in a cycle owner==CPU except starve_cnt.
//  - Reset mid-operation: pending return discarded, no rvalid after rst_n release.
// TESTING
//  1 cpu_req=1 only, addr=0x00010, we=0 -> ram_addr=0x10, cpu_hold=0; next cycle cpu_rdata=ram_rdata.
//  2 cpu_req=1 continuous, ext_req=01 -> 8 cycles CPU owner, cycle 9 ext_gnt=01, cpu_hold=1 one cycle.
//  3 cpu_req=0, ext_req=11 held -> gnt order 01,10,01,10; rvalid matches prior gnt one cycle later.
//  4 ext master 1 write we=4'b0011 data=0xDEADBEEF -> ram_we=0011 same cycle, no ext_rvalid.
//  5 starve_cnt=STARVE_LIMIT-1 then ext_req drops -> starve_cnt=0, CPU never held.
//  6 rst_n low while read to ext 0 in flight -> all outputs 0, no rvalid after release.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Data-side RAM port arbiter: the CPU has fixed priority, and the external masters share
// the port round-robin with a forced slot once a request has been starved for STARVE_LIMIT cycles.
module mem_port_arbiter #(
  parameter int NUM_EXT      = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cpu_req,
  input  logic [17:0]             cpu_addr,
  input  logic [3:0]              cpu_we,
  input  logic [31:0]             cpu_wdata,
  output logic [31:0]             cpu_rdata,
  output logic                    cpu_hold,
  input  logic [NUM_EXT-1:0]      ext_req,
  input  logic [18*NUM_EXT-1:0]   ext_addr,
  input  logic [4*NUM_EXT-1:0]    ext_we,
  input  logic [32*NUM_EXT-1:0]   ext_wdata,
  output logic [NUM_EXT-1:0]      ext_gnt,
  output logic [NUM_EXT-1:0]      ext_rvalid,
  output logic [31:0]             ext_rdata,
  output logic [17:0]             ram_addr,
  output logic [3:0]              ram_we,
  output logic [31:0]             ram_wdata,
  input  logic [31:0]             ram_rdata
);

  localparam int PW = (NUM_EXT > 1) ? $clog2(NUM_EXT) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [PW-1:0]      rr_ptr;
  logic [SW-1:0]      starve_cnt;
  logic               ret_cpu;
  logic [NUM_EXT-1:0] ret_ext;
  logic [31:0]        cpu_last, ext_last;

  logic               force_ext, own_cpu, own_ext, hit_hi;
  logic [PW-1:0]      sel, sel_hi, sel_lo;

  // Rotating priority: the first requester at or above rr_ptr wins.
  // If there is none, the lowest-numbered requester wins (wrap).
  always_comb begin
    force_ext = (starve_cnt == SW'(STARVE_LIMIT)) && (|ext_req);
    own_cpu   = cpu_req && !force_ext;
    hit_hi    = 1'b0;
    sel_hi    = '0;
    sel_lo    = '0;
    for (int i = NUM_EXT - 1; i >= 0; i--) begin
      if (ext_req[i]) begin
        sel_lo = PW'(i);
        if (PW'(i) >= rr_ptr) begin
          sel_hi = PW'(i);
          hit_hi = 1'b1;
        end
      end
    end
    sel     = hit_hi ? sel_hi : sel_lo;
    own_ext = !own_cpu && (|ext_req);
  end

  always_comb begin
    ram_addr  = '0;
    ram_we    = '0;
    ram_wdata = '0;
    ext_gnt   = '0;
    if (own_cpu) begin
      ram_addr  = cpu_addr;
      ram_we    = cpu_we;
      ram_wdata = cpu_wdata;
    end else if (own_ext) begin
      ram_addr     = ext_addr[18*sel +: 18];
      ram_we       = ext_we[4*sel +: 4];
      ram_wdata    = ext_wdata[32*sel +: 32];
      ext_gnt[sel] = 1'b1;
    end
  end

  assign cpu_hold   = cpu_req && !own_cpu;
  assign ext_rvalid = ret_ext;
  assign cpu_rdata  = ret_cpu    ? ram_rdata : cpu_last;
  assign ext_rdata  = |ret_ext   ? ram_rdata : ext_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      starve_cnt <= '0;
      ret_cpu    <= 1'b0;
      ret_ext    <= '0;
      cpu_last   <= '0;
      ext_last   <= '0;
    end else begin
      if (own_ext)
        rr_ptr <= (sel == PW'(NUM_EXT - 1)) ? '0 : sel + PW'(1);
      if (own_ext || ext_req == '0)
        starve_cnt <= '0;
      else if (own_cpu && starve_cnt != SW'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + SW'(1);
      // Only reads schedule a return on the following cycle.
      ret_cpu <= own_cpu && (cpu_we == 4'b0);
      ret_ext <= (own_ext && ram_we == 4'b0) ? ext_gnt : '0;
      if (ret_cpu)  cpu_last <= ram_rdata;
      if (|ret_ext) ext_last <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and random stimulus for mem_port_arbiter, checked every cycle against a
// rule-level reference model that includes its own RAM image.
module tb_mem_port_arbiter;
  localparam int NE  = 2;
  localparam int LIM = 8;

  logic clk = 1'b0, rst_n = 1'b0;
  logic cpu_req = 1'b0, cpu_hold;
  logic [17:0] cpu_addr = '0, ram_addr;
  logic [3:0]  cpu_we = '0, ram_we;
  logic [31:0] cpu_wdata = '0, cpu_rdata, ext_rdata, ram_wdata, ram_rdata;
  logic [NE-1:0] ext_req = '0, ext_gnt, ext_rvalid;
  logic [18*NE-1:0] ext_addr = '0;
  logic [4*NE-1:0]  ext_we = '0;
  logic [32*NE-1:0] ext_wdata = '0;

  mem_port_arbiter #(.NUM_EXT(NE), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_hold(cpu_hold),
    .ext_req(ext_req), .ext_addr(ext_addr), .ext_we(ext_we), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM with one cycle of read latency, read-before-write; only the low 8 address bits are decoded.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr[7:0]];
    for (int b = 0; b < 4; b++)
      if (ram_we[b]) mem[ram_addr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
  end

  int errors = 0, checks = 0;
  // Reference model state. Owner encoding: -2 = none, -1 = CPU, i = ext master i.
  int m_rr, m_st, m_ret;
  logic [31:0] m_rd, m_lc, m_le;
  logic [NE-1:0] p_gnt, obs_gnt, obs_rv;
  logic p_hold, obs_hold;
  logic [3:0] obs_we;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [NE-1:0] eg, erv;
    logic eh;
    logic [17:0] ea;
    logic [3:0] ew;
    logic [31:0] ed, ecd, eed;
    int own;
    bit any, frc;
    @(negedge clk);
    if (!rst_n) begin
      m_rr = 0; m_st = 0; m_ret = -2; m_rd = '0; m_lc = '0; m_le = '0;
    end
    any = |ext_req;
    frc = (m_st == LIM) && any;
    own = -2;
    if (cpu_req && !frc) own = -1;
    else
      for (int k = 0; k < NE; k++) begin
        int j = (m_rr + k) % NE;
        if (own == -2 && ext_req[j]) own = j;
      end
    eg = '0; ea = '0; ew = '0; ed = '0;
    if (own == -1) begin
      ea = cpu_addr; ew = cpu_we; ed = cpu_wdata;
    end else if (own >= 0) begin
      eg[own] = 1'b1;
      ea = ext_addr[18*own +: 18]; ew = ext_we[4*own +: 4]; ed = ext_wdata[32*own +: 32];
    end
    eh  = cpu_req && (own != -1);
    erv = '0;
    if (m_ret >= 0) erv[m_ret] = 1'b1;
    ecd = (m_ret == -1) ? m_rd : m_lc;
    eed = (m_ret >= 0)  ? m_rd : m_le;
    chk("ext_gnt", 32'(ext_gnt), 32'(eg));
    chk("cpu_hold", 32'(cpu_hold), 32'(eh));
    chk("ram_addr", 32'(ram_addr), 32'(ea));
    chk("ram_we", 32'(ram_we), 32'(ew));
    chk("ram_wdata", ram_wdata, ed);
    chk("ext_rvalid", 32'(ext_rvalid), 32'(erv));
    chk("cpu_rdata", cpu_rdata, ecd);
    chk("ext_rdata", ext_rdata, eed);
    obs_gnt = ext_gnt; obs_rv = ext_rvalid; obs_hold = cpu_hold; obs_we = ram_we;
    if (rst_n) begin
      if (m_ret == -1) m_lc = m_rd;
      if (m_ret >= 0)  m_le = m_rd;
      if (own != -2 && ew == 4'b0) begin
        m_ret = own; m_rd = mem[ea[7:0]];
      end else m_ret = -2;
      if (own >= 0 || !any) m_st = 0;
      else if (own == -1 && m_st < LIM) m_st++;
      if (own >= 0) m_rr = (own + 1) % NE;
    end
    p_gnt  = rst_n ? eg : '0;
    p_hold = rst_n ? eh : 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_req = 1'b0; cpu_addr = '0; cpu_we = '0; cpu_wdata = '0;
    ext_req = '0; ext_addr = '0; ext_we = '0; ext_wdata = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic set_ext(input int i, input logic [17:0] a, input logic [3:0] w,
                         input logic [31:0] d);
    ext_req[i] = 1'b1;
    ext_addr[18*i +: 18] = a;
    ext_we[4*i +: 4] = w;
    ext_wdata[32*i +: 32] = d;
  endtask

  int gcyc, holds, rvs;
  logic [NE-1:0] g [4];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    do_reset();

    // Single CPU read.
    cpu_req = 1'b1; cpu_addr = 18'h00010; cpu_we = 4'b0;
    step();
    chk("t1_hold", 32'(obs_hold), 32'd0);
    idle();
    step();

    // Continuous CPU traffic starves master 0 until the forced slot.
    cpu_req = 1'b1; cpu_addr = 18'h00033;
    set_ext(0, 18'h00044, 4'b0, 32'h0);
    gcyc = 0; holds = 0;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (obs_gnt[0] && gcyc == 0) gcyc = c;
      if (obs_hold) holds++;
      if (p_gnt[0]) ext_req[0] = 1'b0;
    end
    chk("t2_gnt_cycle", 32'(gcyc), 32'd9);
    chk("t2_hold_cycles", 32'(holds), 32'd1);
    idle();
    step();

    // Two masters alternate in round-robin order.
    do_reset();
    set_ext(0, 18'h00001, 4'b0, 32'h0);
    set_ext(1, 18'h00002, 4'b0, 32'h0);
    for (int c = 0; c < 4; c++) begin
      step();
      g[c] = obs_gnt;
      for (int i = 0; i < NE; i++)
        if (p_gnt[i]) ext_addr[18*i +: 18] = 18'($urandom_range(0, 255));
    end
    chk("t3_gnt0", 32'(g[0]), 32'd1);
    chk("t3_gnt1", 32'(g[1]), 32'd2);
    chk("t3_gnt2", 32'(g[2]), 32'd1);
    chk("t3_gnt3", 32'(g[3]), 32'd2);
    idle();
    step();

    // External write produces no read return.
    set_ext(1, 18'h00020, 4'b0011, 32'hDEADBEEF);
    step();
    chk("t4_we", 32'(obs_we), 32'd3);
    idle();
    step();
    chk("t4_no_rvalid", 32'(obs_rv), 32'd0);

    // Starve counter cleared by a dropped request: the CPU is never held.
    holds = 0;
    cpu_req = 1'b1; cpu_addr = 18'h00050;
    set_ext(0, 18'h00060, 4'b0, 32'h0);
    for (int c = 0; c < 7; c++) begin step(); if (obs_hold) holds++; end
    ext_req = '0;
    step(); if (obs_hold) holds++;
    ext_req[0] = 1'b1;
    for (int c = 0; c < 8; c++) begin step(); if (obs_hold) holds++; end
    chk("t5_hold_cnt", 32'(holds), 32'd0);
    idle();
    step();

    // Reset while a read to master 0 is in flight.
    set_ext(0, 18'h00070, 4'b0, 32'h0);
    step();
    idle();
    rst_n = 1'b0;
    step();
    chk("t6_rvalid_in_rst", 32'(obs_rv), 32'd0);
    rst_n = 1'b1;
    rvs = 0;
    for (int c = 0; c < 3; c++) begin step(); if (|obs_rv) rvs++; end
    chk("t6_rvalid_after", 32'(rvs), 32'd0);

    // Random traffic that obeys the hold-until-grant protocol.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NE; i++)
        if (!(ext_req[i] && !p_gnt[i])) begin
          if ($urandom_range(0, 2) == 0)
            set_ext(i, 18'($urandom), ($urandom_range(0, 1) == 0) ? 4'b0 : 4'($urandom),
                    $urandom);
          else ext_req[i] = 1'b0;
        end
      if (!p_hold) begin
        cpu_req   = 1'($urandom_range(0, 1));
        cpu_addr  = 18'($urandom);
        cpu_we    = ($urandom_range(0, 1) == 0) ? 4'b0 : 4'($urandom);
        cpu_wdata = $urandom;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
